// File: rtl/mvm_pkg.sv
// Shared MVM weight-write definitions: tuser field offsets, the weight-write
// opcode and the weight loader state encoding.
package mvm_pkg;

  localparam int ADDR_LSB = 0;
  localparam int OP_LSB   = 9;
  localparam int RFEN_LSB = 11;

  localparam logic [1:0] OP_WEIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } wl_state_t;

endpackage

// File: rtl/wl_fifo.sv
// Synchronous row buffer with full/empty flags; the head word is always
// presented from the storage registers so a pop and its data share a cycle.
module wl_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_write;
  logic             do_read;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_write = wen && !full;
  assign do_read  = ren && !empty;
  assign rdata    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/weight_loader.sv
// Turns buffered 512-bit weight rows into AXI-Stream weight-write packets for
// one MVM register file, addressing rows 0..count-1 with tlast on the final row.
module weight_loader
  import mvm_pkg::*;
#(
  parameter int DATAW      = 512,
  parameter int USERW      = 75,
  parameter int IDW        = 2,
  parameter int DESTW      = 4,
  parameter int DPES       = 64,
  parameter int RF_DEPTH   = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [DESTW-1:0]            cmd_dest,
  input  logic [$clog2(DPES)-1:0]     cmd_dpe,
  input  logic [$clog2(RF_DEPTH):0]   cmd_count,
  output logic                        cmd_done,
  output logic                        cmd_err,
  input  logic                        data_fifo_wen,
  input  logic [DATAW-1:0]            data_fifo_wdata,
  output logic                        data_fifo_rdy,
  output logic                        axis_tx_tvalid,
  input  logic                        axis_tx_tready,
  output logic [DATAW+USERW-1:0]      axis_tx_tdata,
  output logic [IDW-1:0]              axis_tx_tid,
  output logic [DESTW-1:0]            axis_tx_tdest,
  output logic                        axis_tx_tlast
);

  localparam int AW   = $clog2(RF_DEPTH);
  localparam int DPEW = $clog2(DPES);

  wl_state_t         state;
  wl_state_t         next_state;

  logic [DESTW-1:0]  dest_q;
  logic [DPEW-1:0]   dpe_q;
  logic [AW:0]       count_q;
  logic [AW:0]       load_idx;
  logic              err_q;

  logic              out_valid;
  logic              out_last;
  logic [DATAW-1:0]  out_row;
  logic [USERW-1:0]  out_user;
  logic [USERW-1:0]  next_user;
  logic [DPES-1:0]   rf_en;

  logic [DATAW-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  logic              accept;
  logic              cmd_ok;
  logic              tx_fire;
  logic              load;

  wl_fifo #(
    .WIDTH (DATAW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wen   (data_fifo_wen),
    .wdata (data_fifo_wdata),
    .ren   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign accept  = cmd_valid && cmd_ready;
  assign cmd_ok  = (cmd_count != '0) && (cmd_count <= (AW+1)'(RF_DEPTH));
  assign tx_fire = out_valid && axis_tx_tready;

  // The output register refills whenever it is free or draining this cycle,
  // but never pulls more rows than the command asked for.
  assign load = (state == STREAM) && (!out_valid || axis_tx_tready) &&
                !fifo_empty && (load_idx < count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && cmd_ok)     next_state = STREAM;
      STREAM:  if (tx_fire && out_last)  next_state = DONE;
      DONE:                              next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted, not just once it has clocked in.
  always_comb begin
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    case (state)
      IDLE:    cmd_ready = !rst;
      DONE:    cmd_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q   <= '0;
      dpe_q    <= '0;
      count_q  <= '0;
      load_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !cmd_ok;
      if (accept && cmd_ok) begin
        dest_q   <= cmd_dest;
        dpe_q    <= cmd_dpe;
        count_q  <= cmd_count;
        load_idx <= '0;
      end else if (load) begin
        load_idx <= load_idx + 1'b1;
      end
    end
  end

  assign rf_en = DPES'(1) << dpe_q;

  always_comb begin
    next_user                     = '0;
    next_user[ADDR_LSB +: AW]     = load_idx[AW-1:0];
    next_user[OP_LSB +: 2]        = OP_WEIGHT;
    next_user[RFEN_LSB +: DPES]   = rf_en;
  end

  // tuser is captured with the row so a stalled flit cannot change under the NoC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_user  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= (load_idx == count_q - (AW+1)'(1));
      out_row   <= fifo_rdata;
      out_user  <= next_user;
    end else if (tx_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign cmd_err        = err_q;
  assign data_fifo_rdy  = !fifo_full;
  assign axis_tx_tvalid = out_valid;
  assign axis_tx_tdata  = {out_user, out_row};
  assign axis_tx_tid    = '0;
  assign axis_tx_tdest  = dest_q;
  assign axis_tx_tlast  = out_last;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: randomized rows and backpressure,
// compared every cycle against a queue-based packet model.
module tb_weight_loader;

  localparam int DATAW      = 512;
  localparam int USERW      = 75;
  localparam int IDW        = 2;
  localparam int DESTW      = 4;
  localparam int DPES       = 64;
  localparam int RF_DEPTH   = 512;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 9;
  localparam int TW         = DATAW + USERW;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DESTW-1:0]  cmd_dest;
  logic [5:0]        cmd_dpe;
  logic [AW:0]       cmd_count;
  logic              cmd_done;
  logic              cmd_err;
  logic              data_fifo_wen;
  logic [DATAW-1:0]  data_fifo_wdata;
  logic              data_fifo_rdy;
  logic              axis_tx_tvalid;
  logic              axis_tx_tready;
  logic [TW-1:0]     axis_tx_tdata;
  logic [IDW-1:0]    axis_tx_tid;
  logic [DESTW-1:0]  axis_tx_tdest;
  logic              axis_tx_tlast;

  always #5 clk = ~clk;

  weight_loader #(
    .DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW),
    .DPES(DPES), .RF_DEPTH(RF_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dest        (cmd_dest),
    .cmd_dpe         (cmd_dpe),
    .cmd_count       (cmd_count),
    .cmd_done        (cmd_done),
    .cmd_err         (cmd_err),
    .data_fifo_wen   (data_fifo_wen),
    .data_fifo_wdata (data_fifo_wdata),
    .data_fifo_rdy   (data_fifo_rdy),
    .axis_tx_tvalid  (axis_tx_tvalid),
    .axis_tx_tready  (axis_tx_tready),
    .axis_tx_tdata   (axis_tx_tdata),
    .axis_tx_tid     (axis_tx_tid),
    .axis_tx_tdest   (axis_tx_tdest),
    .axis_tx_tlast   (axis_tx_tlast)
  );

  typedef struct {
    logic [TW-1:0]    data;
    logic [DESTW-1:0] dest;
    logic             last;
  } flit_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: rows pushed but not yet delivered, plus the active command.
  logic [DATAW-1:0] row_q[$];
  logic [DATAW-1:0] feed_q[$];
  flit_t            flit_log[$];
  bit               busy, done_pend, err_pend;
  bit               exp_done, exp_err;
  int               m_dest, m_dpe, m_count, m_idx, occ;
  int               done_seen = 0;
  int               err_seen  = 0;
  bit               stall_prev;
  flit_t            stall_flit;
  logic [DATAW-1:0] m_row;
  int               tready_mode = 0;

  task automatic check_word(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] expect_flit(input int dpe, input int addr, input logic [DATAW-1:0] row);
    logic [USERW-1:0] u;
    u          = '0;
    u[11+dpe]  = 1'b1;
    u[10:9]    = 2'b11;
    u[8:0]     = addr[8:0];
    return {u, row};
  endfunction

  function automatic logic [DATAW-1:0] rand_row();
    logic [DATAW-1:0] r;
    for (int k = 0; k < DATAW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Compare process: one pass per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      row_q.delete();
      busy = 0; done_pend = 0; err_pend = 0; stall_prev = 0;
    end else begin
      exp_done = done_pend;
      exp_err  = err_pend;
      occ      = row_q.size() - (axis_tx_tvalid ? 1 : 0);
      check_bit("cmd_ready", cmd_ready, !busy);
      check_bit("cmd_done", cmd_done, exp_done);
      check_bit("cmd_err", cmd_err, exp_err);
      check_bit("data_fifo_rdy", data_fifo_rdy, occ < FIFO_DEPTH);
      check_int("tid", int'(axis_tx_tid), 0);
      if (cmd_done) done_seen++;
      if (cmd_err)  err_seen++;
      if (exp_done) busy = 0;
      done_pend = 0;
      err_pend  = 0;
      if (stall_prev) begin
        check_bit("stall_tvalid", axis_tx_tvalid, 1'b1);
        check_word("stall_tdata", axis_tx_tdata, stall_flit.data);
        check_int("stall_tdest", int'(axis_tx_tdest), int'(stall_flit.dest));
        check_bit("stall_tlast", axis_tx_tlast, stall_flit.last);
      end
      stall_prev      = axis_tx_tvalid && !axis_tx_tready;
      stall_flit.data = axis_tx_tdata;
      stall_flit.dest = axis_tx_tdest;
      stall_flit.last = axis_tx_tlast;
      if (axis_tx_tvalid && !busy) check_bit("tvalid_idle", axis_tx_tvalid, 1'b0);
      if (axis_tx_tvalid && axis_tx_tready) begin
        if (row_q.size() == 0) begin
          check_int("flit_without_row", 1, 0);
        end else begin
          m_row = row_q.pop_front();
          check_word("tdata", axis_tx_tdata, expect_flit(m_dpe, m_idx, m_row));
          check_int("tdest", int'(axis_tx_tdest), m_dest);
          check_bit("tlast", axis_tx_tlast, m_idx == m_count - 1);
        end
        flit_log.push_back(stall_flit);
        if (m_idx == m_count - 1) done_pend = 1;
        m_idx++;
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_count == 0 || int'(cmd_count) > RF_DEPTH) begin
          err_pend = 1;
        end else begin
          busy    = 1;
          m_dest  = int'(cmd_dest);
          m_dpe   = int'(cmd_dpe);
          m_count = int'(cmd_count);
          m_idx   = 0;
        end
      end
      if (data_fifo_wen) begin
        if (!data_fifo_rdy) check_bit("push_when_full", 1'b1, 1'b0);
        else                row_q.push_back(data_fifo_wdata);
      end
    end
  end

  initial begin
    axis_tx_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0:       axis_tx_tready = 1'b1;
        1:       axis_tx_tready = !axis_tx_tready;
        2:       axis_tx_tready = 1'($urandom_range(0, 1));
        default: axis_tx_tready = 1'b0;
      endcase
    end
  end

  initial begin
    data_fifo_wen   = 1'b0;
    data_fifo_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && feed_q.size() > 0 && data_fifo_rdy) begin
        data_fifo_wen   = 1'b1;
        data_fifo_wdata = feed_q.pop_front();
      end else begin
        data_fifo_wen   = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input int dest, input int dpe, input int count);
    bit took = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dest  = dest[DESTW-1:0];
    cmd_dpe   = dpe[5:0];
    cmd_count = count[AW:0];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        took = 1;
        break;
      end
    end
    if (!took) check_bit("cmd_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_seen;
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_seen > start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check_bit("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_output(input int nflits, input int dest, input logic [63:0] rfen, input int base);
    logic [TW-1:0] lit;
    check_int("log_size", flit_log.size(), nflits);
    for (int i = 0; i < nflits && i < flit_log.size(); i++) begin
      lit = {rfen, 2'b11, 9'(i), 512'(32'(base) + 32'(i))};
      check_word("lit_tdata", flit_log[i].data, lit);
      check_int("lit_tdest", int'(flit_log[i].dest), dest);
      check_bit("lit_tlast", flit_log[i].last, i == nflits - 1);
    end
  endtask

  initial begin
    int e0, bad_addr, nlast, cnt;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_dest = '0; cmd_dpe = '0; cmd_count = '0;
    repeat (3) @(posedge clk);
    #3;
    check_bit("rst_cmd_ready", cmd_ready, 1'b0);
    check_bit("rst_tvalid", axis_tx_tvalid, 1'b0);
    check_word("rst_tdata", axis_tx_tdata, '0);
    check_bit("rst_rdy", data_fifo_rdy, 1'b1);
    check_bit("rst_done", cmd_done, 1'b0);
    check_bit("rst_err", cmd_err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_bit("post_rst_ready", cmd_ready, 1'b1);

    $display("[TB] basic 4-row packet");
    flit_log.delete();
    for (int i = 0; i < 4; i++) feed_q.push_back(DATAW'(32'hA0 + 32'(i)));
    apply_stimulus(3, 5, 4);
    wait_done(200);
    check_output(4, 3, 64'h20, 32'hA0);

    $display("[TB] same packet with toggling tready");
    tready_mode = 1;
    flit_log.delete();
    for (int i = 0; i < 4; i++) feed_q.push_back(DATAW'(32'hA0 + 32'(i)));
    apply_stimulus(3, 5, 4);
    wait_done(200);
    check_output(4, 3, 64'h20, 32'hA0);
    tready_mode = 0;

    $display("[TB] FIFO fills in IDLE");
    flit_log.delete();
    for (int i = 0; i < 10; i++) feed_q.push_back(DATAW'(32'h100 + 32'(i)));
    repeat (15) @(posedge clk);
    #2;
    check_bit("fifo_full_rdy", data_fifo_rdy, 1'b0);
    check_int("rows_waiting", feed_q.size(), 2);
    apply_stimulus(7, 0, 10);
    wait_done(300);
    check_output(10, 7, 64'h1, 32'h100);

    $display("[TB] rejected counts");
    flit_log.delete();
    e0 = err_seen;
    apply_stimulus(1, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    check_int("err_count0", err_seen, e0 + 1);
    check_bit("err_ready0", cmd_ready, 1'b1);
    apply_stimulus(1, 1, 513);
    repeat (3) @(posedge clk);
    #2;
    check_int("err_count513", err_seen, e0 + 2);
    check_int("err_no_flits", flit_log.size(), 0);

    $display("[TB] full register file, dpe 63");
    flit_log.delete();
    for (int i = 0; i < 512; i++) feed_q.push_back(rand_row());
    apply_stimulus(9, 63, 512);
    wait_done(3000);
    check_int("full_log_size", flit_log.size(), 512);
    bad_addr = 0;
    nlast    = 0;
    foreach (flit_log[i]) begin
      if (int'(flit_log[i].data[DATAW +: 9]) != i) bad_addr++;
      if (flit_log[i].data[DATAW+74] !== 1'b1) bad_addr++;
      if (flit_log[i].last) nlast++;
    end
    check_int("full_addr_errors", bad_addr, 0);
    check_int("full_tlast_count", nlast, 1);

    $display("[TB] reset mid-packet");
    flit_log.delete();
    feed_q.push_back(rand_row());
    feed_q.push_back(rand_row());
    apply_stimulus(2, 7, 4);
    for (int i = 0; i < 100 && flit_log.size() < 2; i++) @(negedge clk);
    check_int("pre_rst_flits", flit_log.size(), 2);
    tready_mode = 3;
    feed_q.push_back(rand_row());
    repeat (4) @(posedge clk);
    #2;
    check_bit("pre_rst_tvalid", axis_tx_tvalid, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_bit("async_tvalid", axis_tx_tvalid, 1'b0);
    check_word("async_tdata", axis_tx_tdata, '0);
    check_bit("async_tlast", axis_tx_tlast, 1'b0);
    check_int("async_tdest", int'(axis_tx_tdest), 0);
    check_bit("async_ready", cmd_ready, 1'b0);
    feed_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tready_mode = 0;
    flit_log.delete();
    feed_q.push_back(DATAW'(32'h55));
    apply_stimulus(5, 2, 1);
    wait_done(100);
    check_output(1, 5, 64'h4, 32'h55);

    $display("[TB] randomized commands");
    tready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      if (n % 7 == 3) begin
        apply_stimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
                       (n % 2 == 0) ? 0 : int'($urandom_range(513, 1023)));
        repeat (3) @(posedge clk);
      end else begin
        cnt = int'($urandom_range(1, 40));
        for (int i = 0; i < cnt; i++) feed_q.push_back(rand_row());
        apply_stimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)), cnt);
        wait_done(1000);
      end
    end
    repeat (5) @(posedge clk);
    #2;
    check_int("feed_drained", feed_q.size(), 0);
    check_int("model_rows_left", row_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
